// File: rtl/ngy_alu_pkg.sv
// Shared ALU control codes and default widths for the ALU sharing logic.
package ngy_alu_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CTRL_W_DEF = 4;
   localparam int CNT_W_DEF  = 16;

   localparam logic [3:0] ALU_AND       = 4'd0;
   localparam logic [3:0] ALU_OR        = 4'd1;
   localparam logic [3:0] ALU_ADD       = 4'd2;
   localparam logic [3:0] ALU_SUB       = 4'd6;
   localparam logic [3:0] ALU_IDLE_CTRL = ALU_ADD;

   typedef enum logic {
      OWN_0 = 1'b0,
      OWN_1 = 1'b1
   } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; ptr names the requester that wins a tie.
module rr_arb2 (
   input  logic [1:0] elig,
   input  logic       ptr,
   output logic [1:0] grant,
   output logic       ptr_nxt
);

   always_comb begin
      grant   = 2'b00;
      ptr_nxt = ptr;
      case (elig)
         2'b01: begin
            grant   = 2'b01;
            ptr_nxt = 1'b1;
         end
         2'b10: begin
            grant   = 2'b10;
            ptr_nxt = 1'b0;
         end
         2'b11: begin
            grant   = ptr ? 2'b10 : 2'b01;
            ptr_nxt = ~ptr;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters:
// round-robin accept, registered ALU operands, result captured one cycle later.
import ngy_alu_pkg::*;

module alu_share_arbiter #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk_74a,
   input  logic              reset_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [CTRL_W-1:0] req1_ctrl,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_result,
   output logic              rsp0_zero,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_result,
   output logic              rsp1_zero,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [CTRL_W-1:0] alu_control,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_zero,
   output logic [CNT_W-1:0]  done0_cnt,
   output logic [CNT_W-1:0]  done1_cnt,
   output logic              busy
);

   logic [1:0]              w_elig;
   logic [1:0]              w_grant;
   logic [1:0]              w_iss_mask;
   logic [1:0]              w_rsp_ack;
   logic                    w_ptr_nxt;

   logic                    r_ptr;
   logic                    r_iss_vld;
   owner_e                  r_iss_own;
   logic [DATA_W-1:0]       r_alu_a;
   logic [DATA_W-1:0]       r_alu_b;
   logic [CTRL_W-1:0]       r_alu_ctrl;
   logic [1:0]              r_rsp_vld;
   logic [1:0][DATA_W-1:0]  r_rsp_res;
   logic [1:0]              r_rsp_zero;
   logic [1:0][CNT_W-1:0]   r_cnt;

   // A requester stays ineligible while its op is in issue or its result is held,
   // so a consume only frees it on the following cycle.
   assign w_iss_mask = !r_iss_vld ? 2'b00 : ((r_iss_own == OWN_1) ? 2'b10 : 2'b01);
   assign w_elig     = {req1_valid, req0_valid} & ~r_rsp_vld & ~w_iss_mask;
   assign w_rsp_ack  = r_rsp_vld & {rsp1_ready, rsp0_ready};

   rr_arb2 u_arb (
      .elig    (w_elig),
      .ptr     (r_ptr),
      .grant   (w_grant),
      .ptr_nxt (w_ptr_nxt)
   );

   assign req0_ready = w_grant[0] & reset_n;
   assign req1_ready = w_grant[1] & reset_n;

   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr      <= 1'b0;
         r_iss_vld  <= 1'b0;
         r_iss_own  <= OWN_0;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_ctrl <= CTRL_W'(ALU_IDLE_CTRL);
      end else begin
         r_ptr     <= w_ptr_nxt;
         r_iss_vld <= |w_grant;
         if (w_grant[1]) begin
            r_iss_own  <= OWN_1;
            r_alu_a    <= req1_a;
            r_alu_b    <= req1_b;
            r_alu_ctrl <= req1_ctrl;
         end else if (w_grant[0]) begin
            r_iss_own  <= OWN_0;
            r_alu_a    <= req0_a;
            r_alu_b    <= req0_b;
            r_alu_ctrl <= req0_ctrl;
         end else begin
            r_iss_own  <= OWN_0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_ctrl <= CTRL_W'(ALU_IDLE_CTRL);
         end
      end
   end

   // Capture and consume never collide for the same requester: eligibility
   // guarantees its held result was gone before the op was accepted.
   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         r_rsp_vld  <= '0;
         r_rsp_res  <= '0;
         r_rsp_zero <= '0;
         r_cnt      <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (w_rsp_ack[k]) begin
               r_rsp_vld[k] <= 1'b0;
               r_cnt[k]     <= r_cnt[k] + CNT_W'(1);
            end
            if (w_iss_mask[k]) begin
               r_rsp_vld[k]  <= 1'b1;
               r_rsp_res[k]  <= alu_out;
               r_rsp_zero[k] <= alu_zero;
            end
         end
      end
   end

   assign alu_a       = r_alu_a;
   assign alu_b       = r_alu_b;
   assign alu_control = r_alu_ctrl;
   assign rsp0_valid  = r_rsp_vld[0];
   assign rsp1_valid  = r_rsp_vld[1];
   assign rsp0_result = r_rsp_res[0];
   assign rsp1_result = r_rsp_res[1];
   assign rsp0_zero   = r_rsp_zero[0];
   assign rsp1_zero   = r_rsp_zero[1];
   assign done0_cnt   = r_cnt[0];
   assign done1_cnt   = r_cnt[1];
   assign busy        = r_iss_vld | (|r_rsp_vld);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench: stimulus queues expected results at accept; a negedge monitor
// checks grants, ALU operands, responses, latency and counters against a simple model.
module tb_alu_share_arbiter;
   import ngy_alu_pkg::*;

   localparam int DW = 32;
   localparam int CW = 4;
   localparam int NW = 4;

   logic          clk_74a = 1'b0;
   logic          reset_n = 1'b0;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [CW-1:0] req0_ctrl, req1_ctrl;
   logic          rsp0_valid, rsp0_ready, rsp0_zero;
   logic          rsp1_valid, rsp1_ready, rsp1_zero;
   logic [DW-1:0] rsp0_result, rsp1_result;
   logic [DW-1:0] alu_a, alu_b, alu_out;
   logic [CW-1:0] alu_control;
   logic          alu_zero;
   logic [NW-1:0] done0_cnt, done1_cnt;
   logic          busy;

   typedef struct {
      logic [31:0] res;
      logic        z;
      int          tag;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   logic last_acc0, last_acc1;

   alu_share_arbiter #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
      .clk_74a(clk_74a), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_ctrl(req0_ctrl),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_ctrl(req1_ctrl),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
      .rsp0_zero(rsp0_zero),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
      .rsp1_zero(rsp1_zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .alu_out(alu_out), .alu_zero(alu_zero),
      .done0_cnt(done0_cnt), .done1_cnt(done1_cnt), .busy(busy)
   );

   always #5 clk_74a = ~clk_74a;
   always @(posedge clk_74a) cyc <= cyc + 1;

   function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
      case (c)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         default: return 32'h0;
      endcase
   endfunction

   // Stand-in for Alu32
   always_comb begin
      alu_out  = alu_f(alu_control, alu_a, alu_b);
      alu_zero = (alu_out == 32'h0);
   end

   function automatic logic [31:0] rnd_word();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         default: return $urandom();
      endcase
   endfunction

   function automatic logic [3:0] rnd_ctrl();
      case ($urandom_range(0, 5))
         0:       return ALU_AND;
         1:       return ALU_OR;
         2:       return ALU_ADD;
         3:       return ALU_SUB;
         default: return 4'($urandom_range(0, 15));
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic drive(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c);
      if (k == 0) begin
         req0_a = a; req0_b = b; req0_ctrl = c; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_ctrl = c; req1_valid = 1'b1;
      end
   endtask

   // Called at posedge+1 with inputs set; records accepts, advances one cycle.
   task automatic tick();
      exp_t e;
      #1;
      last_acc0 = req0_valid & req0_ready;
      last_acc1 = req1_valid & req1_ready;
      if (last_acc0) begin
         e.res = alu_f(req0_ctrl, req0_a, req0_b); e.z = (e.res == 32'h0); e.tag = cyc;
         q0.push_back(e);
      end
      if (last_acc1) begin
         e.res = alu_f(req1_ctrl, req1_a, req1_b); e.z = (e.res == 32'h0); e.tag = cyc;
         q1.push_back(e);
      end
      @(posedge clk_74a);
      #1;
      if (last_acc0) req0_valid = 1'b0;
      if (last_acc1) req1_valid = 1'b0;
   endtask

   task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, output logic [31:0] res, output logic z,
                        output int lat);
      int n;
      logic got;
      drive(k, a, b, c);
      n = 0;
      do begin
         tick();
         n++;
         got = (k == 0) ? last_acc0 : last_acc1;
      end while (!got && n < 10);
      res = '0; z = 1'b0; lat = 99;
      if (!got) begin
         req0_valid = 1'b0; req1_valid = 1'b0;
         return;
      end
      n = 0;
      while (!((k == 0) ? rsp0_valid : rsp1_valid) && n < 10) begin
         tick();
         n++;
      end
      if (n < 10) begin
         lat = n + 1;
         res = (k == 0) ? rsp0_result : rsp1_result;
         z   = (k == 0) ? rsp0_zero : rsp1_zero;
         tick();
      end
   endtask

   // Monitor: behavioural model of eligibility / round-robin plus response scoreboard
   initial begin
      logic [1:0]  outst, v, el, g, rv, rr, pv, pr;
      logic        last_win, p_acc;
      logic [31:0] p_a, p_b, pres0, pres1;
      logic [3:0]  p_c;
      logic        pz0, pz1;
      int          ecnt0, ecnt1;
      exp_t        e;
      outst = '0; last_win = 1'b1; p_acc = 1'b0; pv = '0; pr = '0;
      p_a = '0; p_b = '0; p_c = ALU_IDLE_CTRL; ecnt0 = 0; ecnt1 = 0;
      pres0 = '0; pres1 = '0; pz0 = 1'b0; pz1 = 1'b0;
      forever begin
         @(negedge clk_74a);
         if (!reset_n) begin
            chk("rst alu_control", alu_control, ALU_IDLE_CTRL);
            chk("rst alu_a", alu_a, 0);
            chk("rst busy", busy, 0);
            chk("rst rsp_valid", {rsp1_valid, rsp0_valid}, 0);
            chk("rst cnt", {done1_cnt, done0_cnt}, 0);
            chk("rst ready", {req1_ready, req0_ready}, 0);
            outst = '0; last_win = 1'b1; p_acc = 1'b0; pv = '0; pr = '0;
            ecnt0 = 0; ecnt1 = 0;
            q0.delete(); q1.delete();
            continue;
         end
         v  = {req1_valid, req0_valid};
         rv = {rsp1_valid, rsp0_valid};
         rr = {rsp1_ready, rsp0_ready};
         if (p_acc) begin
            chk("alu_a", alu_a, p_a);
            chk("alu_b", alu_b, p_b);
            chk("alu_control", alu_control, p_c);
         end else begin
            chk("idle alu_a", alu_a, 0);
            chk("idle alu_b", alu_b, 0);
            chk("idle alu_control", alu_control, ALU_IDLE_CTRL);
         end
         chk("busy", busy, p_acc | (|rv));
         chk("done0_cnt", done0_cnt, ecnt0 % (1 << NW));
         chk("done1_cnt", done1_cnt, ecnt1 % (1 << NW));
         // held responses stay stable
         if (pv[0] && !pr[0]) begin
            chk("rsp0 held", {rsp0_valid, rsp0_zero, rsp0_result}, {1'b1, pz0, pres0});
         end else if (rsp0_valid) begin
            if (q0.size() == 0) chk("rsp0 unexpected", 1, 0);
            else begin
               e = q0.pop_front();
               chk("rsp0 latency", cyc, e.tag + 2);
               chk("rsp0 result", {rsp0_zero, rsp0_result}, {e.z, e.res});
            end
         end
         if (pv[1] && !pr[1]) begin
            chk("rsp1 held", {rsp1_valid, rsp1_zero, rsp1_result}, {1'b1, pz1, pres1});
         end else if (rsp1_valid) begin
            if (q1.size() == 0) chk("rsp1 unexpected", 1, 0);
            else begin
               e = q1.pop_front();
               chk("rsp1 latency", cyc, e.tag + 2);
               chk("rsp1 result", {rsp1_zero, rsp1_result}, {e.z, e.res});
            end
         end
         if (q0.size() > 0 && cyc > q0[0].tag + 2) begin
            chk("rsp0 missing", 0, 1); void'(q0.pop_front());
         end
         if (q1.size() > 0 && cyc > q1[0].tag + 2) begin
            chk("rsp1 missing", 0, 1); void'(q1.pop_front());
         end
         // one op outstanding per requester; ties go to whoever lost last time
         el = v & ~outst;
         if (el == 2'b11) g = last_win ? 2'b01 : 2'b10;
         else             g = el;
         chk("grant", {req1_ready, req0_ready}, g);
         p_acc = (g != 2'b00);
         if (p_acc) begin
            outst    = outst | g;
            last_win = g[1];
            p_a = g[1] ? req1_a : req0_a;
            p_b = g[1] ? req1_b : req0_b;
            p_c = g[1] ? req1_ctrl : req0_ctrl;
         end
         outst = outst & ~(rv & rr);
         if (rv[0] && rr[0]) ecnt0++;
         if (rv[1] && rr[1]) ecnt1++;
         pv = rv; pr = rr;
         pres0 = rsp0_result; pz0 = rsp0_zero;
         pres1 = rsp1_result; pz1 = rsp1_zero;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] res;
      logic        z;
      int          lat;
      req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req0_ctrl = 0;
      req1_a = 0; req1_b = 0; req1_ctrl = 0; rsp0_ready = 1; rsp1_ready = 1;
      last_acc0 = 0; last_acc1 = 0;
      repeat (2) @(posedge clk_74a);
      #1;
      reset_n = 1'b1;

      // both valid in the first cycle after reset
      drive(0, 32'd3, 32'd4, ALU_ADD);
      drive(1, 32'd9, 32'd2, ALU_SUB);
      tick();
      chk("t3 first grant", {last_acc1, last_acc0}, 2'b01);
      tick();
      chk("t3 second grant", {last_acc1, last_acc0}, 2'b10);
      chk("t3 rsp0", {rsp0_valid, rsp0_result}, {1'b1, 32'd7});
      tick();
      chk("t3 rsp1", {rsp1_valid, rsp1_result}, {1'b1, 32'd7});
      tick();
      chk("t3 idle", {alu_control, alu_a, alu_b}, {ALU_IDLE_CTRL, 64'h0});

      do_op(0, 32'h5400_0008, 32'h1, ALU_ADD, res, z, lat);
      chk("t1 latency", lat, 2);
      chk("t1 result", {z, res}, {1'b0, 32'h5400_0009});
      chk("t1 done0_cnt", done0_cnt, 2);

      do_op(1, 32'h5, 32'h5, ALU_SUB, res, z, lat);
      chk("t2 sub", {z, res}, {1'b1, 32'h0});
      do_op(1, 32'hF0, 32'h3C, ALU_AND, res, z, lat);
      chk("t2 and", {z, res}, {1'b0, 32'h30});

      // rsp0 back-pressure while req1 keeps running
      rsp0_ready = 1'b0;
      drive(0, 32'h11, 32'h22, ALU_OR);
      tick();
      for (int i = 0; i < 8; i++) begin
         if (!req0_valid) drive(0, rnd_word(), rnd_word(), rnd_ctrl());
         if (!req1_valid) drive(1, rnd_word(), rnd_word(), rnd_ctrl());
         #1 chk("t4 req0_ready low", req0_ready, 0);
         tick();
      end
      req1_valid = 1'b0;
      rsp0_ready = 1'b1;
      tick();
      #1 chk("t4 req0 re-accept", req0_ready, 1);
      tick();
      repeat (4) tick();

      // reset during the issue cycle
      drive(0, 32'h1, 32'h2, ALU_ADD);
      tick();
      chk("t5 accept", last_acc0, 1);
      #1 reset_n = 1'b0;
      req1_valid = 1'b1;
      #1;
      chk("t5 async ctrl", alu_control, ALU_IDLE_CTRL);
      chk("t5 async ops", {alu_a, alu_b}, 64'h0);
      chk("t5 async flags", {busy, rsp0_valid, req0_ready, req1_ready}, 4'b0000);
      @(posedge clk_74a);
      #1;
      reset_n = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1 chk("t5 no rsp0", rsp0_valid, 0);
         tick();
      end
      chk("t5 done0_cnt", done0_cnt, 0);

      // counter wrap
      for (int i = 0; i < 15; i++) do_op(1, i, 32'h1, ALU_ADD, res, z, lat);
      chk("t6 done1 max", done1_cnt, 15);
      do_op(1, 32'h7, 32'h8, ALU_OR, res, z, lat);
      chk("t6 done1 wrap", done1_cnt, 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if (!req0_valid && $urandom_range(0, 2) != 0) drive(0, rnd_word(), rnd_word(), rnd_ctrl());
         if (!req1_valid && $urandom_range(0, 2) != 0) drive(1, rnd_word(), rnd_word(), rnd_ctrl());
         rsp0_ready = ($urandom_range(0, 3) != 0);
         rsp1_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      repeat (6) tick();
      chk("drain q0", q0.size(), 0);
      chk("drain q1", q1.size(), 0);
      chk("drain busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
